// File: rtl/load_store_unit_if.sv
// Request/response and data_memory bus of load_store_unit, plus the data_memory
// write-control encoding shared by the unit and whatever drives/models data_memory.
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    DATA_MEM_NO_WR = 2'd0,
    DATA_MEM_B_WR  = 2'd1,
    DATA_MEM_H_WR  = 2'd2,
    DATA_MEM_W_WR  = 2'd3
  } DataMemWrControl;
endpackage

interface load_store_unit_if;
  import load_store_unit_pkg::*;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while the unit is idle, and request fields are ignored
  // otherwise. resp_valid is a single-cycle pulse with no back-pressure; resp_rdata
  // and resp_fault hold until the next response.
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_fault;
  DataMemWrControl mem_wr;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wr_data;
  logic [31:0]     mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_wr, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_wr, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Blocking load/store unit between execute and data_memory with range/size checks.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_MEM_DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [32:0] LAST_BYTE = 33'(DATA_MEM_DEPTH * 4 - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wr_data;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic [32:0] w_nbytes;
  logic [32:0] w_last;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_ext;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

  always_comb begin
    w_nbytes = 33'd4;
    case (bus.req_size)
      2'b00:   w_nbytes = 33'd1;
      2'b01:   w_nbytes = 33'd2;
      default: w_nbytes = 33'd4;
    endcase
  end

  // 33-bit end address so a request near 2^32 cannot wrap back into range.
  assign w_last = {1'b0, bus.req_addr} + w_nbytes - 33'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = (bus.req_size == 2'b11) || (w_last > LAST_BYTE) || w_misalign;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.req_valid) w_next = w_fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:   w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ext = bus.mem_rd_data;
    case (r_size)
      2'b00:   w_ext = {{24{~r_unsigned & bus.mem_rd_data[7]}}, bus.mem_rd_data[7:0]};
      2'b01:   w_ext = {{16{~r_unsigned & bus.mem_rd_data[15]}}, bus.mem_rd_data[15:0]};
      default: w_ext = bus.mem_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_mem_wr_data <= 32'd0;
      r_resp_valid  <= 1'b0;
      r_resp_fault  <= 1'b0;
      r_resp_rdata  <= 32'd0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        if (w_fault) begin
          r_resp_fault <= 1'b1;
          r_resp_rdata <= 32'd0;
        end else begin
          r_mem_addr    <= bus.req_addr;
          r_mem_wr_data <= bus.req_wdata;
        end
      end
      // Response registers only change on the edge that enters RESP.
      if ((r_state == ST_ACCESS) && r_we) begin
        r_resp_fault <= 1'b0;
        r_resp_rdata <= 32'd0;
      end
      if (r_state == ST_WAIT) begin
        r_resp_fault <= 1'b0;
        r_resp_rdata <= w_ext;
      end
    end
  end

  // Write strobe is decoded combinationally so reset can suppress an in-flight store.
  always_comb begin
    bus.mem_wr = DATA_MEM_NO_WR;
    if (!rst && (r_state == ST_ACCESS) && r_we) begin
      case (r_size)
        2'b00:   bus.mem_wr = DATA_MEM_B_WR;
        2'b01:   bus.mem_wr = DATA_MEM_H_WR;
        default: bus.mem_wr = DATA_MEM_W_WR;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_fault  = r_resp_fault;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array data_memory model, byte-level
// reference model of load/store semantics, directed scenarios and random traffic.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int DEPTH = 512;
  localparam int NB    = DEPTH * 4;

  int n_vec = 0;
  int n_bad = 0;
  int wr_seen = 0;

  logic [7:0]  mem     [NB];
  logic [7:0]  ref_mem [NB];
  logic [31:0] exp_q [$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  logic [1:0] dbg_state;

  load_store_unit #(.DATA_MEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- data_memory model ----------------
  always @(posedge clk) begin
    logic [31:0] rd;
    int n;
    for (int i = 0; i < 4; i++)
      rd[8*i +: 8] = (longint'(bus.mem_addr) + i < NB) ? mem[int'(bus.mem_addr) + i] : 8'h00;
    bus.mem_rd_data <= rd;
    case (bus.mem_wr)
      DATA_MEM_B_WR: n = 1;
      DATA_MEM_H_WR: n = 2;
      DATA_MEM_W_WR: n = 4;
      default:       n = 0;
    endcase
    for (int i = 0; i < n; i++)
      if (longint'(bus.mem_addr) + i < NB) mem[int'(bus.mem_addr) + i] <= bus.mem_wr_data[8*i +: 8];
  end

  always @(negedge clk) if (bus.mem_wr !== DATA_MEM_NO_WR) wr_seen++;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_fault(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (longint'(addr) + nbytes(size) - 1 > NB - 1) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((longint'(addr) % nbytes(size)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic ref_apply(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] e_rdata, output logic e_fault,
                           output int e_lat, output int e_wr);
    int n;
    longint v;
    n = nbytes(size);
    if (ref_fault(size, addr)) begin
      e_rdata = 32'd0; e_fault = 1'b1; e_lat = 1; e_wr = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      e_rdata = 32'd0; e_fault = 1'b0; e_lat = 2; e_wr = 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e_rdata = v[31:0]; e_fault = 1'b0; e_lat = 3; e_wr = 0;
    end
  endtask

  task automatic preload(input int addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      mem[addr + i]     = word[8*i +: 8];
      ref_mem[addr + i] = word[8*i +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic fault, output int lat,
                        output int wr_cycles, output DataMemWrControl wr_kind,
                        output logic one_pulse);
    int budget;
    rdata = 'x; fault = 1'bx; lat = 0; wr_cycles = 0; wr_kind = DATA_MEM_NO_WR; one_pulse = 1'b0;
    @(negedge clk);
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    budget = 20;
    while (bus.req_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.mem_wr !== DATA_MEM_NO_WR) begin
        wr_cycles++;
        wr_kind = bus.mem_wr;
      end
      if (bus.resp_valid === 1'b1) begin
        lat = k; rdata = bus.resp_rdata; fault = bus.resp_fault;
        break;
      end
    end
    @(negedge clk);
    one_pulse = (bus.resp_valid === 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.mem_wr !== DATA_MEM_NO_WR) begin n_bad++; $display("FAIL rst_mem_wr: got %0d, required 0", bus.mem_wr); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b, required 0", bus.resp_valid); end
    n_vec++; if (bus.resp_fault !== 1'b0) begin n_bad++; $display("FAIL rst_resp_fault: got %b, required 0", bus.resp_fault); end
    n_vec++; if (bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h, required 0", bus.resp_rdata); end
    n_vec++; if (bus.mem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr); end
    n_vec++; if (bus.mem_wr_data !== 32'd0) begin n_bad++; $display("FAIL rst_mem_wr_data: got %h, required 0", bus.mem_wr_data); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); end
  endtask

  task automatic test_loads();
    logic [1:0] sz [5]  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic       un [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         ad [5]  = '{4, 5, 5, 6, 6};
    logic [31:0] ex [5] = '{32'hAABBCCDD, 32'hFFFFFFCC, 32'h000000CC, 32'hFFFFAABB, 32'h0000AABB};
    logic [31:0] rd, er; logic f, ef, p; int lat, el, wc, ew; DataMemWrControl wk;
    preload(4, 32'hAABBCCDD);
    for (int t = 0; t < 5; t++) begin
      ref_apply(1'b0, sz[t], un[t], ad[t], 32'd0, er, ef, el, ew);
      do_req(1'b0, sz[t], un[t], ad[t], $urandom, rd, f, lat, wc, wk, p);
      n_vec++; if (rd !== ex[t]) begin n_bad++; $display("FAIL load_rdata[%0d]: got %h, required %h", t, rd, ex[t]); end
      n_vec++; if (lat !== 3 || f !== 1'b0) begin n_bad++; $display("FAIL load_lat_fault[%0d]: got lat %0d fault %b, required 3/0", t, lat, f); end
      n_vec++; if (wc !== 0 || p !== 1'b1) begin n_bad++; $display("FAIL load_nowr_pulse[%0d]: got wr %0d pulse %b, required 0/1", t, wc, p); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd, er; logic f, ef, p; int lat, el, wc, ew; DataMemWrControl wk;
    preload(16, 32'h0);
    ref_apply(1'b1, 2'b01, 1'b0, 16, 32'h11223344, er, ef, el, ew);
    do_req(1'b1, 2'b01, 1'b0, 16, 32'h11223344, rd, f, lat, wc, wk, p);
    n_vec++; if (wc !== 1 || wk !== DATA_MEM_H_WR) begin n_bad++; $display("FAIL sh_wr: got %0d cycles kind %0d, required 1 H_WR", wc, wk); end
    n_vec++; if (lat !== 2 || f !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL sh_resp: got lat %0d fault %b rdata %h, required 2/0/0", lat, f, rd); end
    do_req(1'b0, 2'b10, 1'b0, 16, 32'd0, rd, f, lat, wc, wk, p);
    n_vec++; if (rd !== 32'h00003344) begin n_bad++; $display("FAIL lw_after_sh: got %h, required 00003344", rd); end
    ref_apply(1'b1, 2'b00, 1'b0, 16, 32'h000000EE, er, ef, el, ew);
    do_req(1'b1, 2'b00, 1'b0, 16, 32'h000000EE, rd, f, lat, wc, wk, p);
    n_vec++; if (wc !== 1 || wk !== DATA_MEM_B_WR || lat !== 2) begin n_bad++; $display("FAIL sb_wr: got %0d cycles kind %0d lat %0d, required 1 B_WR 2", wc, wk, lat); end
    do_req(1'b0, 2'b10, 1'b0, 16, 32'd0, rd, f, lat, wc, wk, p);
    n_vec++; if (rd !== 32'h000033EE) begin n_bad++; $display("FAIL lw_after_sb: got %h, required 000033EE", rd); end
  endtask

  task automatic test_range();
    logic [1:0]  sz [4] = '{2'b10, 2'b10, 2'b00, 2'b11};
    logic [31:0] ad [4] = '{32'd2044, 32'd2045, 32'd2048, 32'd0};
    logic [31:0] rd; logic f, p; int lat, wc, w0; DataMemWrControl wk;
    preload(2044, 32'h04030201);
    do_req(1'b0, sz[0], 1'b0, ad[0], 32'd0, rd, f, lat, wc, wk, p);
    n_vec++; if (f !== 1'b0 || rd !== 32'h04030201 || lat !== 3) begin n_bad++; $display("FAIL lw_2044: got fault %b rdata %h lat %0d, required 0/04030201/3", f, rd, lat); end
    for (int t = 1; t < 4; t++) begin
      w0 = wr_seen;
      do_req(t == 3, sz[t], 1'b0, ad[t], 32'hDEADBEEF, rd, f, lat, wc, wk, p);
      n_vec++; if (f !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL range_fault[%0d]: got fault %b rdata %h, required 1/0", t, f, rd); end
      n_vec++; if (lat !== 1 || wr_seen !== w0) begin n_bad++; $display("FAIL range_lat_wr[%0d]: got lat %0d writes %0d, required 1/0", t, lat, wr_seen - w0); end
    end
  endtask

  task automatic test_reset_mid();
    int budget, w0, rv;
    preload(12, 32'h12345678);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd12; bus.req_wdata = 32'hFFBBAAEE; bus.req_valid = 1'b1;
    budget = 20;
    while (bus.req_ready !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    w0 = wr_seen;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.mem_wr !== DATA_MEM_NO_WR) begin n_bad++; $display("FAIL rstmid_mem_wr: got %0d, required 0", bus.mem_wr); end
    @(negedge clk);
    rst = 1'b0;
    rv = 0;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b, required 1", bus.req_ready); end
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid !== 1'b0) rv++;
      @(negedge clk);
    end
    n_vec++; if (rv !== 0 || wr_seen !== w0) begin n_bad++; $display("FAIL rstmid_no_resp_wr: got %0d resp %0d writes, required 0/0", rv, wr_seen - w0); end
    n_vec++; if ({mem[15], mem[14], mem[13], mem[12]} !== 32'h12345678) begin
      n_bad++; $display("FAIL rstmid_mem: got %h, required 12345678", {mem[15], mem[14], mem[13], mem[12]});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd, rd; int budget, gap, lat;
    logic [31:0] er; logic ef; int el, ew;
    wd = $urandom;
    ref_apply(1'b1, 2'b10, 1'b0, 20, wd, er, ef, el, ew);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd20; bus.req_wdata = wd; bus.req_valid = 1'b1;
    budget = 20;
    while (bus.req_ready !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_wdata = ~wd;
    gap = 1;
    while (bus.req_ready !== 1'b1 && gap < 10) begin @(negedge clk); gap++; end
    n_vec++; if (gap !== 3) begin n_bad++; $display("FAIL b2b_ready_gap: got %0d, required 3", gap); end
    @(posedge clk);
    lat = 0; rd = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin lat = k; rd = bus.resp_rdata; break; end
    end
    n_vec++; if (lat !== 3 || rd !== wd) begin n_bad++; $display("FAIL b2b_load: got lat %0d rdata %h, required 3/%h", lat, rd, wd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic f, p; int lat, wc; DataMemWrControl wk;
    mem[13] = 8'h11; mem[14] = 8'h22; mem[15] = 8'h33; mem[16] = 8'h44;
    ref_mem[13] = 8'h11; ref_mem[14] = 8'h22; ref_mem[15] = 8'h33; ref_mem[16] = 8'h44;
    do_req(1'b0, 2'b10, 1'b0, 13, 32'd0, rd, f, lat, wc, wk, p);
`ifdef LSU_MISALIGN_TRAP_EN
    n_vec++; if (f !== 1'b1 || rd !== 32'd0 || lat !== 1) begin n_bad++; $display("FAIL misalign: got fault %b rdata %h lat %0d, required 1/0/1", f, rd, lat); end
`else
    n_vec++; if (f !== 1'b0 || rd !== 32'h44332211 || lat !== 3) begin n_bad++; $display("FAIL misalign: got fault %b rdata %h lat %0d, required 0/44332211/3", f, rd, lat); end
`endif
  endtask

  task automatic test_random();
    logic we, uns, f, ef, p; logic [1:0] sz; logic [31:0] ad, wd, rd, er;
    int lat, el, wc, ew, bad_bytes; DataMemWrControl wk;
    for (int t = 0; t < 80; t++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      ad  = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                         : 32'($urandom_range(0, NB + 4));
      wd  = $urandom;
      ref_apply(we, sz, uns, ad, wd, er, ef, el, ew);
      exp_q.push_back(er);
      do_req(we, sz, uns, ad, wd, rd, f, lat, wc, wk, p);
      er = exp_q.pop_front();
      n_vec++; if (rd !== er || f !== ef) begin n_bad++; $display("FAIL rand_resp[%0d]: we %b sz %0d addr %h got %h/%b, required %h/%b", t, we, sz, ad, rd, f, er, ef); end
      n_vec++; if (lat !== el || wc !== ew || p !== 1'b1) begin n_bad++; $display("FAIL rand_timing[%0d]: got lat %0d wr %0d pulse %b, required %0d/%0d/1", t, lat, wc, p, el, ew); end
    end
    bad_bytes = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
    n_vec++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL mem_image: got %0d differing bytes, required 0", bad_bytes); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NB; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    test_reset();
    test_loads();
    test_stores();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
